// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: byte PC, synchronous-read instruction memory with a preload port,
// and a credit-controlled instruction queue feeding decode through a valid/ready handshake.
module if_fetch_queue #(
    parameter int              XLEN        = 32,
    parameter int              IMEM_DEPTH  = 256,
    parameter int              QUEUE_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC    = '0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           redirect_valid,
    input  logic [XLEN-1:0]                redirect_pc,
    input  logic                           imem_wr_en,
    input  logic [$clog2(IMEM_DEPTH)-1:0]  imem_wr_addr,
    input  logic [31:0]                    imem_wr_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [31:0]                    out_instr,
    output logic [XLEN-1:0]                out_pc,
    output logic                           out_misaligned,
    output logic [6:0]                     out_op,
    output logic [2:0]                     out_funct3,
    output logic [6:0]                     out_funct7,
    output logic [$clog2(QUEUE_DEPTH):0]   queue_count
);

    localparam int          AW  = $clog2(IMEM_DEPTH);
    localparam int          PW  = $clog2(QUEUE_DEPTH);
    localparam int          CW  = PW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            halt_q, halt_d;
    logic            inflight_q, inflight_d;
    logic            inflight_mis_q, inflight_mis_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic [31:0]     imem [IMEM_DEPTH];
    logic [31:0]     rdata_q;
    logic [31:0]     q_instr [QUEUE_DEPTH];
    logic [XLEN-1:0] q_pc [QUEUE_DEPTH];
    logic            q_mis [QUEUE_DEPTH];

    logic            issue;
    logic            fetch_mis;
    logic            push;
    logic            pop;
    logic [CW-1:0]   credit_used;

    // An in-flight read already owns a queue slot, so counting it here makes overflow impossible.
    always_comb begin
        credit_used = count_q + CW'(inflight_q);
        fetch_mis   = (fetch_pc_q[1:0] != 2'b00);
        issue       = !halt_q && !redirect_valid && (credit_used < CW'(QUEUE_DEPTH));
        push        = inflight_q && !redirect_valid;
        pop         = out_valid && out_ready;
    end

    always_comb begin
        fetch_pc_d     = fetch_pc_q;
        halt_d         = halt_q;
        inflight_d     = issue;
        inflight_mis_d = fetch_mis;
        inflight_pc_d  = fetch_pc_q;
        rd_ptr_d       = rd_ptr_q + PW'(pop);
        wr_ptr_d       = wr_ptr_q + PW'(push);
        count_d        = count_q + CW'(push) - CW'(pop);

        if (issue) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
            if (fetch_mis) begin
                halt_d = 1'b1;
            end
        end

        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            halt_d     = 1'b0;
            inflight_d = 1'b0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q     <= RESET_PC;
            halt_q         <= 1'b0;
            inflight_q     <= 1'b0;
            inflight_mis_q <= 1'b0;
            inflight_pc_q  <= '0;
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            count_q        <= '0;
        end else begin
            fetch_pc_q     <= fetch_pc_d;
            halt_q         <= halt_d;
            inflight_q     <= inflight_d;
            inflight_mis_q <= inflight_mis_d;
            inflight_pc_q  <= inflight_pc_d;
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            count_q        <= count_d;
        end
    end

    // Memory contents survive reset so the program can be preloaded while reset is held.
    always_ff @(posedge clk) begin
        if (imem_wr_en) begin
            imem[imem_wr_addr] <= imem_wr_data;
        end
        if (issue && !fetch_mis) begin
            rdata_q <= imem[fetch_pc_q[2 +: AW]];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[wr_ptr_q] <= inflight_mis_q ? NOP : rdata_q;
            q_pc[wr_ptr_q]    <= inflight_pc_q;
            q_mis[wr_ptr_q]   <= inflight_mis_q;
        end
    end

    always_comb begin
        out_valid      = (count_q != '0);
        out_instr      = out_valid ? q_instr[rd_ptr_q] : '0;
        out_pc         = out_valid ? q_pc[rd_ptr_q] : '0;
        out_misaligned = out_valid ? q_mis[rd_ptr_q] : 1'b0;
        out_op         = out_instr[6:0];
        out_funct3     = out_instr[14:12];
        out_funct7     = out_instr[31:25];
        queue_count    = count_q;
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Scoreboard bench for if_fetch_queue: stimulus pushes the expected fetch stream,
// a negedge monitor pops and compares every accepted head entry.
module tb_if_fetch_queue;

    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_wr_en;
    logic [7:0]  imem_wr_addr;
    logic [31:0] imem_wr_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_misaligned;
    logic [6:0]  out_op;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic [2:0]  queue_count;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        mis;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] model_mem [256];
    int          total;
    int          bad;
    int          pops;
    int          p0;

    if_fetch_queue #(
        .XLEN(32),
        .IMEM_DEPTH(256),
        .QUEUE_DEPTH(4),
        .RESET_PC(32'h0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .imem_wr_en(imem_wr_en),
        .imem_wr_addr(imem_wr_addr),
        .imem_wr_data(imem_wr_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instr(out_instr),
        .out_pc(out_pc),
        .out_misaligned(out_misaligned),
        .out_op(out_op),
        .out_funct3(out_funct3),
        .out_funct7(out_funct7),
        .queue_count(queue_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    function automatic void push_stream(input logic [31:0] pc, input int n);
        exp_t e;
        logic [31:0] p;
        p = pc;
        if (p[1:0] != 2'b00) begin
            e.pc = p; e.instr = 32'h0000_0013; e.mis = 1'b1;
            exp_q.push_back(e);
        end else begin
            for (int i = 0; i < n; i++) begin
                e.pc = p; e.instr = model_mem[p[9:2]]; e.mis = 1'b0;
                exp_q.push_back(e);
                p = p + 32'd4;
            end
        end
    endfunction

    task automatic applyStimulus(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
    endtask

    task automatic redirect_end();
        step();
        redirect_valid = 1'b0;
        exp_q.delete();
        push_stream(redirect_pc, 64);
    endtask

    // Every accepted head entry must be the next one the stimulus predicted.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            pops++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_output: got pc=%h expected no output", out_pc);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("out_pc", out_pc, mon_e.pc);
                checkOutput("out_instr", out_instr, mon_e.instr);
                checkOutput("out_misaligned", 32'(out_misaligned), 32'(mon_e.mis));
                checkOutput("out_op", 32'(out_op), 32'(mon_e.instr[6:0]));
                checkOutput("out_funct3", 32'(out_funct3), 32'(mon_e.instr[14:12]));
                checkOutput("out_funct7", 32'(out_funct7), 32'(mon_e.instr[31:25]));
            end
        end
    end

    initial begin
        total = 0; bad = 0; pops = 0;
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        imem_wr_en = 1'b0; imem_wr_addr = '0; imem_wr_data = '0; out_ready = 1'b0;

        for (int i = 0; i < 256; i++) begin
            imem_wr_en   = 1'b1;
            imem_wr_addr = 8'(i);
            imem_wr_data = 32'h13 + (32'(i) << 7);
            model_mem[i] = 32'h13 + (32'(i) << 7);
            step();
        end
        imem_wr_en = 1'b0;
        at_neg();
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_instr", out_instr, 32'd0);
        checkOutput("rst_pc", out_pc, 32'd0);
        checkOutput("rst_mis", 32'(out_misaligned), 32'd0);
        checkOutput("rst_count", 32'(queue_count), 32'd0);
        step();

        // Sequential fetch from reset with decode always ready
        out_ready = 1'b1;
        exp_q.delete();
        push_stream(32'h0, 64);
        reset = 1'b0;
        at_neg(); checkOutput("first_valid_c0", 32'(out_valid), 32'd0);
        step(); at_neg(); checkOutput("first_valid_c1", 32'(out_valid), 32'd0);
        step(); at_neg(); checkOutput("first_valid_c2", 32'(out_valid), 32'd1);
        checkOutput("first_op", 32'(out_op), 32'h13);
        repeat (8) step();
        out_ready = 1'b0;
        checkOutput("seq_pops", 32'(pops), 32'd8);

        // Backpressure saturates the queue, then drains without gaps
        applyStimulus(32'h0);
        redirect_end();
        repeat (10) step();
        at_neg();
        checkOutput("sat_count", 32'(queue_count), 32'd4);
        checkOutput("sat_valid", 32'(out_valid), 32'd1);
        checkOutput("sat_pc", out_pc, 32'h0);
        repeat (3) step();
        at_neg();
        checkOutput("sat_hold_pc", out_pc, 32'h0);
        checkOutput("sat_hold_count", 32'(queue_count), 32'd4);
        step();
        out_ready = 1'b1;
        p0 = pops;
        for (int i = 0; i < 5; i++) begin
            at_neg();
            checkOutput("drain_valid", 32'(out_valid), 32'd1);
            step();
        end
        out_ready = 1'b0;
        checkOutput("drain_pops", 32'(pops - p0), 32'd5);

        // Redirect with three entries queued, popping in the redirect cycle
        applyStimulus(32'h200);
        redirect_end();
        repeat (4) step();
        p0 = pops;
        applyStimulus(32'h40);
        out_ready = 1'b1;
        at_neg();
        checkOutput("pre_redir_count", 32'(queue_count), 32'd3);
        redirect_end();
        at_neg();
        checkOutput("flush_count", 32'(queue_count), 32'd0);
        checkOutput("flush_valid", 32'(out_valid), 32'd0);
        step(); at_neg();
        checkOutput("redir_gap_valid", 32'(out_valid), 32'd0);
        step(); at_neg();
        checkOutput("redir_valid", 32'(out_valid), 32'd1);
        checkOutput("redir_pc", out_pc, 32'h40);
        checkOutput("redir_instr", out_instr, 32'h13 + (32'd16 << 7));
        repeat (6) step();
        out_ready = 1'b0;
        checkOutput("redir_pops", 32'(pops - p0), 32'd7);

        // Misaligned target produces one fault entry, then issue halts
        applyStimulus(32'h42);
        redirect_end();
        out_ready = 1'b1;
        p0 = pops;
        step(); step(); at_neg();
        checkOutput("mis_valid", 32'(out_valid), 32'd1);
        checkOutput("mis_flag", 32'(out_misaligned), 32'd1);
        checkOutput("mis_instr", out_instr, 32'h13);
        checkOutput("mis_pc", out_pc, 32'h42);
        repeat (10) step();
        at_neg();
        checkOutput("halt_valid", 32'(out_valid), 32'd0);
        checkOutput("halt_count", 32'(queue_count), 32'd0);
        checkOutput("halt_pops", 32'(pops - p0), 32'd1);
        applyStimulus(32'h80);
        redirect_end();
        step(); step(); at_neg();
        checkOutput("resume_pc", out_pc, 32'h80);
        repeat (5) step();

        // Write and read of the same word in one cycle returns the old word
        applyStimulus(32'h14);
        redirect_end();
        imem_wr_en   = 1'b1;
        imem_wr_addr = 8'd5;
        imem_wr_data = 32'hDEAD_BEEF;
        step();
        imem_wr_en   = 1'b0;
        model_mem[5] = 32'hDEAD_BEEF;
        step(); at_neg();
        checkOutput("collide_old", out_instr, 32'h0000_0293);
        repeat (5) step();
        applyStimulus(32'h14);
        redirect_end();
        step(); step(); at_neg();
        checkOutput("collide_new", out_instr, 32'hDEAD_BEEF);
        checkOutput("collide_op", 32'(out_op), 32'h6F);
        repeat (4) step();

        // Word index wraps: PC 0x400 reads word 0
        applyStimulus(32'h3F8);
        redirect_end();
        step(); step(); at_neg();
        checkOutput("wrap_pc0", out_pc, 32'h3F8);
        step(); at_neg();
        checkOutput("wrap_pc1", out_pc, 32'h3FC);
        step(); at_neg();
        checkOutput("wrap_pc2", out_pc, 32'h400);
        checkOutput("wrap_instr", out_instr, 32'h13);
        repeat (3) step();

        // Reset (together with a redirect) on a full queue
        out_ready = 1'b0;
        applyStimulus(32'h0);
        redirect_end();
        repeat (8) step();
        at_neg();
        checkOutput("full_before_reset", 32'(queue_count), 32'd4);
        step();
        reset = 1'b1;
        applyStimulus(32'h80);
        step();
        reset = 1'b0;
        redirect_valid = 1'b0;
        exp_q.delete();
        push_stream(32'h0, 64);
        at_neg();
        checkOutput("post_reset_valid", 32'(out_valid), 32'd0);
        checkOutput("post_reset_count", 32'(queue_count), 32'd0);
        out_ready = 1'b1;
        p0 = pops;
        step(); step(); at_neg();
        checkOutput("post_reset_pc", out_pc, 32'h0);
        repeat (8) step();
        out_ready = 1'b0;
        checkOutput("post_reset_pops", 32'(pops - p0), 32'd8);
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
